// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the 16-bit pipelined MIPS core.
// Owns the PC, drives the combinational ROM address and registers the
// returned word into IF/ID. Handles stall, redirect with one-bubble flush,
// and HALT/resume sequencing.
// Optional feature macro: FETCH_PERF_EN adds saturating perf_fetch and
// perf_bubble counters.
module fetch_sequencer #(
    parameter int              N        = 16,
    parameter logic [N-1:0]    RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF,
    parameter logic [N-1:0]    NOP_WORD = 16'hE000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    input  logic         resume,
    input  logic [N-1:0] imem_inst,
    output logic [N-1:0] imem_addr,
    output logic [N-1:0] ifid_inst,
    output logic [N-1:0] ifid_pc1,
    output logic         ifid_valid,
`ifdef FETCH_PERF_EN
    output logic [15:0]  perf_fetch,
    output logic [15:0]  perf_bubble,
`endif
    output logic         halted
);

    typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] inst_q, inst_d;
    logic [N-1:0] pc1_q, pc1_d;
    logic         vld_q, vld_d;
    logic         do_fetch;   // a real word (normal or HALT) enters IF/ID
    logic         do_bubble;  // NOP_WORD enters IF/ID
    logic [N-1:0] pc_plus1;
    logic         is_halt;

    assign pc_plus1 = pc_q + {{(N-1){1'b0}}, 1'b1};
    assign is_halt  = (imem_inst[N-1 -: 4] == HALT_OP);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    // Next-state: redirect beats stall beats HALT detect; in HALTED,
    // redirect (older branch) or resume returns to RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (!redirect_valid && !stall && is_halt) state_d = S_HALTED;
            S_HALTED: if (redirect_valid || resume)             state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    // Outputs / datapath next values for the current state and inputs
    always_comb begin
        pc_d      = pc_q;
        inst_d    = inst_q;
        pc1_d     = pc1_q;
        vld_d     = vld_q;
        do_fetch  = 1'b0;
        do_bubble = 1'b0;
        case (state_q)
            S_RUN: begin
                if (redirect_valid) begin
                    // flush the wrong-path word currently being read
                    pc_d      = redirect_pc;
                    inst_d    = NOP_WORD;
                    vld_d     = 1'b0;
                    do_bubble = 1'b1;
                end else if (!stall) begin
                    // normal fetch and HALT latch share the same IF/ID load
                    pc_d     = pc_plus1;
                    inst_d   = imem_inst;
                    pc1_d    = pc_plus1;
                    vld_d    = 1'b1;
                    do_fetch = 1'b1;
                end
            end
            default: begin
                // HALTED: PC frozen, bubble every cycle, stall ignored
                inst_d    = NOP_WORD;
                vld_d     = 1'b0;
                do_bubble = 1'b1;
                if (redirect_valid) pc_d = redirect_pc;
            end
        endcase
    end

    // PC and IF/ID pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            inst_q <= NOP_WORD;
            pc1_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
            pc1_q  <= pc1_d;
            vld_q  <= vld_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_inst  = inst_q;
    assign ifid_pc1   = pc1_q;
    assign ifid_valid = vld_q;
    assign halted     = (state_q == S_HALTED);

`ifdef FETCH_PERF_EN
    logic [15:0] pf_q, pb_q;

    // Saturating fetch / bubble counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pf_q <= '0;
            pb_q <= '0;
        end else begin
            if (do_fetch  && pf_q != 16'hFFFF) pf_q <= pf_q + 16'd1;
            if (do_bubble && pb_q != 16'hFFFF) pb_q <= pb_q + 16'd1;
        end
    end

    assign perf_fetch  = pf_q;
    assign perf_bubble = pb_q;
`endif

endmodule
